// File: rtl/nasti_lite_writer.sv
// nasti_lite_writer
//   Splits one NASTI (AXI4) write burst into len+1 single-beat NASTI-Lite
//   writes and returns a single merged B response for the whole burst.
//   Only one burst is in flight at a time.
//
//   Optional feature (compile-time macro NASTI_LITE_WLAST_CHECK_EN):
//     master_w_last is checked against the expected final beat. A mismatch
//     raises a sticky error that forces the burst response to at least
//     SLVERR. All len+1 Lite beats are still issued. When the macro is not
//     defined, master_w_last is ignored and only aw_len sets the beat count.

module nasti_lite_writer #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,

  // Upstream burst address channel
  input  logic [ID_WIDTH-1:0]       master_aw_id,
  input  logic [ADDR_WIDTH-1:0]     master_aw_addr,
  input  logic [7:0]                master_aw_len,
  input  logic [2:0]                master_aw_size,
  input  logic [1:0]                master_aw_burst,
  input  logic [2:0]                master_aw_prot,
  input  logic                      master_aw_valid,
  output logic                      master_aw_ready,

  // Upstream write data channel
  input  logic [DATA_WIDTH-1:0]     master_w_data,
  input  logic [DATA_WIDTH/8-1:0]   master_w_strb,
  input  logic                      master_w_last,
  input  logic                      master_w_valid,
  output logic                      master_w_ready,

  // Upstream burst response channel
  output logic [ID_WIDTH-1:0]       master_b_id,
  output logic [1:0]                master_b_resp,
  output logic                      master_b_valid,
  input  logic                      master_b_ready,

  // Downstream Lite address channel
  output logic [ADDR_WIDTH-1:0]     lite_aw_addr,
  output logic [2:0]                lite_aw_prot,
  output logic                      lite_aw_valid,
  input  logic                      lite_aw_ready,

  // Downstream Lite data channel
  output logic [DATA_WIDTH-1:0]     lite_w_data,
  output logic [DATA_WIDTH/8-1:0]   lite_w_strb,
  output logic                      lite_w_valid,
  input  logic                      lite_w_ready,

  // Downstream Lite response channel
  input  logic [1:0]                lite_b_resp,
  input  logic                      lite_b_valid,
  output logic                      lite_b_ready
);

  localparam int          STRB_WIDTH = DATA_WIDTH / 8;
  // Largest size code whose beat still fits the data bus.
  localparam logic [2:0]  MAX_SIZE   = 3'($clog2(STRB_WIDTH));

  localparam logic [1:0]  BURST_FIXED = 2'd0;
  localparam logic [1:0]  BURST_WRAP  = 2'd2;

  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_EXOKAY = 2'd1;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for a burst request
    S_ADDR,   // issuing one Lite AW and one Lite W for the current beat
    S_RESP,   // waiting for the Lite B of the current beat
    S_BRESP   // presenting the merged burst response upstream
  } state_t;

  state_t                 state;

  // Burst context captured at AW acceptance
  logic [ID_WIDTH-1:0]    id_q;
  logic [7:0]             len_q;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;

  // Per-beat progress
  logic [7:0]             cnt_q;
  logic                   aw_done;
  logic                   w_done;
  logic [1:0]             resp_q;

  // Handshakes seen this cycle
  logic                   aw_hs;
  logic                   w_hs;
  logic                   last_beat;

  // Address advance
  logic [2:0]             eff_size;
  logic [ADDR_WIDTH-1:0]  step;
  logic [ADDR_WIDTH-1:0]  wrap_mask;
  logic [ADDR_WIDTH-1:0]  incr_addr;
  logic [ADDR_WIDTH-1:0]  next_addr;

  // Response merge
  logic [1:0]             b_resp_norm;
  logic [1:0]             merged_resp;
  logic [1:0]             final_resp;

  // ---------------------------------------------------------------------
  // Channel controls decoded from the registered state. W is a straight
  // combinational pass-through so data sees no added latency.
  // ---------------------------------------------------------------------
  assign master_aw_ready = (state == S_IDLE);
  assign lite_aw_valid   = (state == S_ADDR) && !aw_done;
  assign lite_w_valid    = (state == S_ADDR) && !w_done && master_w_valid;
  assign master_w_ready  = (state == S_ADDR) && !w_done && lite_w_ready;
  assign lite_w_data     = master_w_data;
  assign lite_w_strb     = master_w_strb;
  assign lite_b_ready    = (state == S_RESP);
  assign master_b_valid  = (state == S_BRESP);
  assign master_b_id     = id_q;
  assign master_b_resp   = resp_q;

  assign aw_hs     = lite_aw_valid && lite_aw_ready;
  assign w_hs      = lite_w_valid && lite_w_ready;
  assign last_beat = (cnt_q == len_q);

  // ---------------------------------------------------------------------
  // Beat stride: the size is capped at the bus width, so oversized
  // requests still step by one full bus word.
  // ---------------------------------------------------------------------
  assign eff_size  = (size_q > MAX_SIZE) ? MAX_SIZE : size_q;
  assign step      = ADDR_WIDTH'(1) << eff_size;
  // WRAP window is (len+1)*step bytes; legal wrap lengths make it a power
  // of two, so the window is described by a simple low-bit mask.
  assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << eff_size)
                     - ADDR_WIDTH'(1);
  assign incr_addr = lite_aw_addr + step;

  // Address of the following beat, selected by burst type.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no
    // path through the case leaves it unassigned and infers a latch.
    next_addr = incr_addr;
    case (burst_q)
      BURST_FIXED: next_addr = lite_aw_addr;
      BURST_WRAP:  next_addr = (lite_aw_addr & ~wrap_mask) |
                               (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;  // INCR and the reserved encoding
    endcase
  end

  // ---------------------------------------------------------------------
  // Response merge: severity order is OKAY < SLVERR < DECERR. A Lite
  // slave has no exclusive access, so EXOKAY is folded into OKAY.
  // ---------------------------------------------------------------------
  assign b_resp_norm = (lite_b_resp == RESP_EXOKAY) ? RESP_OKAY : lite_b_resp;
  assign merged_resp = (b_resp_norm > resp_q) ? b_resp_norm : resp_q;

`ifdef NASTI_LITE_WLAST_CHECK_EN
  logic wlast_err;

  assign final_resp = (wlast_err && (merged_resp < RESP_SLVERR)) ?
                      RESP_SLVERR : merged_resp;

  // Sticky flag: master_w_last must be set on the final beat and only there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wlast_err <= 1'b0;
    end else if (master_aw_valid && master_aw_ready) begin
      wlast_err <= 1'b0;
    end else if (w_hs && (master_w_last != last_beat)) begin
      wlast_err <= 1'b1;
    end
  end
`else
  // master_w_last carries no meaning in this build.
  logic unused_wlast;
  assign unused_wlast = master_w_last;
  assign final_resp   = merged_resp;
`endif

  // Burst sequencer: captures the request, walks the beats and holds the
  // merged response until the upstream master takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the datapath registers are reset as well as the state, because
      // lite_aw_addr/prot and the B fields are visible outputs that must
      // read zero out of reset and after an abandoned burst.
      state        <= S_IDLE;
      id_q         <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      cnt_q        <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      resp_q       <= RESP_OKAY;
      lite_aw_addr <= '0;
      lite_aw_prot <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // read in this block sees the value from before the clock edge.
      case (state)
        S_IDLE: begin
          if (master_aw_valid) begin
            id_q         <= master_aw_id;
            lite_aw_addr <= master_aw_addr;
            len_q        <= master_aw_len;
            size_q       <= master_aw_size;
            burst_q      <= master_aw_burst;
            lite_aw_prot <= master_aw_prot;
            cnt_q        <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            resp_q       <= RESP_OKAY;
            state        <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // Both halves of the beat may complete in the same cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state <= S_RESP;
          end
        end

        S_RESP: begin
          if (lite_b_valid) begin
            if (last_beat) begin
              resp_q <= final_resp;
              state  <= S_BRESP;
            end else begin
              resp_q       <= merged_resp;
              cnt_q        <= cnt_q + 8'd1;
              lite_aw_addr <= next_addr;
              aw_done      <= 1'b0;
              w_done       <= 1'b0;
              state        <= S_ADDR;
            end
          end
        end

        S_BRESP: begin
          if (master_b_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nasti_lite_writer.sv
// tb_nasti_lite_writer
//   Drives bursts into nasti_lite_writer through a master agent and a
//   Lite slave agent (both plain procedural state in this module), then
//   compares the observed Lite beats and burst response against a model
//   computed from the burst parameters with ordinary arithmetic.

module tb_nasti_lite_writer;

  localparam int IW = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  logic [IW-1:0] master_aw_id;
  logic [AW-1:0] master_aw_addr;
  logic [7:0]    master_aw_len;
  logic [2:0]    master_aw_size;
  logic [1:0]    master_aw_burst;
  logic [2:0]    master_aw_prot;
  logic          master_aw_valid;
  logic          master_aw_ready;
  logic [DW-1:0] master_w_data;
  logic [SW-1:0] master_w_strb;
  logic          master_w_last;
  logic          master_w_valid;
  logic          master_w_ready;
  logic [IW-1:0] master_b_id;
  logic [1:0]    master_b_resp;
  logic          master_b_valid;
  logic          master_b_ready;
  logic [AW-1:0] lite_aw_addr;
  logic [2:0]    lite_aw_prot;
  logic          lite_aw_valid;
  logic          lite_aw_ready;
  logic [DW-1:0] lite_w_data;
  logic [SW-1:0] lite_w_strb;
  logic          lite_w_valid;
  logic          lite_w_ready;
  logic [1:0]    lite_b_resp;
  logic          lite_b_valid;
  logic          lite_b_ready;

  nasti_lite_writer #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .master_aw_id    (master_aw_id),
    .master_aw_addr  (master_aw_addr),
    .master_aw_len   (master_aw_len),
    .master_aw_size  (master_aw_size),
    .master_aw_burst (master_aw_burst),
    .master_aw_prot  (master_aw_prot),
    .master_aw_valid (master_aw_valid),
    .master_aw_ready (master_aw_ready),
    .master_w_data   (master_w_data),
    .master_w_strb   (master_w_strb),
    .master_w_last   (master_w_last),
    .master_w_valid  (master_w_valid),
    .master_w_ready  (master_w_ready),
    .master_b_id     (master_b_id),
    .master_b_resp   (master_b_resp),
    .master_b_valid  (master_b_valid),
    .master_b_ready  (master_b_ready),
    .lite_aw_addr    (lite_aw_addr),
    .lite_aw_prot    (lite_aw_prot),
    .lite_aw_valid   (lite_aw_valid),
    .lite_aw_ready   (lite_aw_ready),
    .lite_w_data     (lite_w_data),
    .lite_w_strb     (lite_w_strb),
    .lite_w_valid    (lite_w_valid),
    .lite_w_ready    (lite_w_ready),
    .lite_b_resp     (lite_b_resp),
    .lite_b_valid    (lite_b_valid),
    .lite_b_ready    (lite_b_ready)
  );

  // Result counters
  int n_vec = 0;
  int n_err = 0;

  // Agent state
  bit            rdy_rand;
  int            aw_stall;
  bit            aw_pend, w_hold, b_hold;
  logic [1:0]    b_cur;
  int            aw_cnt, w_cnt, b_cnt, viol, exp_beats;
  int            cyc, aw_cyc, bv_cyc;
  bit            seen_bv, b_done;
  logic [IW-1:0] got_bid;
  logic [1:0]    got_bresp;

  // Upstream beats waiting to be offered, and copies of what was sent
  logic [DW-1:0] wq_data[$];
  logic [SW-1:0] wq_strb[$];
  logic          wq_last[$];
  logic [DW-1:0] sent_data[$];
  logic [SW-1:0] sent_strb[$];

  // Scripted Lite responses (random once empty) and responses actually given
  logic [1:0]    rq[$];
  logic [1:0]    exp_r[$];

  // What the Lite slave observed
  logic [AW-1:0] cap_addr[$];
  logic [2:0]    cap_prot[$];
  logic [DW-1:0] cap_data[$];
  logic [SW-1:0] cap_strb[$];

  // Previous-cycle observations for hold/stability rules
  bit            p_lav, p_lahs, p_lwv, p_lwhs, p_bv, p_bhs;
  logic [AW-1:0] p_laddr;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_agents();
    aw_pend = 0; w_hold = 0; b_hold = 0; b_cur = 2'd0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; viol = 0; aw_stall = 0;
    seen_bv = 0; b_done = 0;
    p_lav = 0; p_lahs = 0; p_lwv = 0; p_lwhs = 0; p_bv = 0; p_bhs = 0;
    p_laddr = '0;
    wq_data.delete(); wq_strb.delete(); wq_last.delete();
    rq.delete(); exp_r.delete();
    cap_addr.delete(); cap_prot.delete(); cap_data.delete(); cap_strb.delete();
    master_aw_valid = 0; master_w_valid = 0; master_w_last = 0;
    master_w_data = '0; master_w_strb = '0; master_b_ready = 0;
    lite_aw_ready = 0; lite_w_ready = 0; lite_b_valid = 0; lite_b_resp = 2'd0;
  endtask

  // One clock: drive on the falling edge, observe just before the rising edge.
  task automatic step();
    int m;
    bit m_aw_hs, m_w_hs, l_aw_hs, l_w_hs, l_b_hs, m_b_hs;
    @(negedge clk);
    master_aw_valid = aw_pend;
    if (!w_hold && wq_data.size() > 0 && (!rdy_rand || $urandom_range(3) != 0))
      w_hold = 1;
    master_w_valid = w_hold;
    if (w_hold) begin
      master_w_data = wq_data[0];
      master_w_strb = wq_strb[0];
      master_w_last = wq_last[0];
    end else begin
      master_w_data = DW'($urandom);
      master_w_strb = SW'($urandom);
      master_w_last = 1'($urandom_range(1));
    end
    master_b_ready = !rdy_rand || ($urandom_range(1) != 0);
    if (aw_stall > 0) begin
      lite_aw_ready = 0;
      aw_stall--;
    end else begin
      lite_aw_ready = !rdy_rand || ($urandom_range(2) != 0);
    end
    lite_w_ready = !rdy_rand || ($urandom_range(2) != 0);
    m = (aw_cnt < w_cnt) ? aw_cnt : w_cnt;
    if (!b_hold && b_cnt < m && (!rdy_rand || $urandom_range(2) != 0)) begin
      b_hold = 1;
      b_cur  = (rq.size() > 0) ? rq.pop_front() : 2'($urandom_range(3));
      exp_r.push_back(b_cur);
    end
    lite_b_valid = b_hold;
    lite_b_resp  = b_hold ? b_cur : 2'd0;

    #4;
    cyc++;
    m_aw_hs = master_aw_valid && master_aw_ready;
    m_w_hs  = master_w_valid && master_w_ready;
    l_aw_hs = lite_aw_valid && lite_aw_ready;
    l_w_hs  = lite_w_valid && lite_w_ready;
    l_b_hs  = lite_b_valid && lite_b_ready;
    m_b_hs  = master_b_valid && master_b_ready;

    // W must stall until the burst has been accepted
    if (m_w_hs && aw_pend) viol++;
    if (m_w_hs != l_w_hs) viol++;
    if (l_w_hs && (lite_w_data !== master_w_data || lite_w_strb !== master_w_strb))
      viol++;
    if (m_aw_hs) begin
      aw_pend = 0;
      aw_cyc  = cyc;
    end
    // A beat's AW/W may only be taken once the previous beat has its B
    if (l_aw_hs) begin
      if (aw_cnt != b_cnt) viol++;
      cap_addr.push_back(lite_aw_addr);
      cap_prot.push_back(lite_aw_prot);
      aw_cnt++;
    end
    if (l_w_hs) begin
      if (w_cnt != b_cnt) viol++;
      cap_data.push_back(lite_w_data);
      cap_strb.push_back(lite_w_strb);
      w_cnt++;
    end
    if (m_w_hs) begin
      void'(wq_data.pop_front());
      void'(wq_strb.pop_front());
      void'(wq_last.pop_front());
      w_hold = 0;
    end
    if (l_b_hs) begin
      b_hold = 0;
      b_cnt++;
    end
    // Valids hold until their handshake; address stable while waiting
    if (p_lav && !p_lahs && (!lite_aw_valid || lite_aw_addr !== p_laddr)) viol++;
    if (p_lwv && !p_lwhs && !lite_w_valid) viol++;
    if (p_bv && !p_bhs && !master_b_valid) viol++;
    if (master_b_valid && !seen_bv) begin
      seen_bv = 1;
      bv_cyc  = cyc;
      if (b_cnt != exp_beats) viol++;
    end
    if (m_b_hs) begin
      b_done    = 1;
      got_bid   = master_b_id;
      got_bresp = master_b_resp;
    end
    p_lav = lite_aw_valid; p_lahs = l_aw_hs; p_laddr = lite_aw_addr;
    p_lwv = lite_w_valid;  p_lwhs = l_w_hs;
    p_bv  = master_b_valid; p_bhs = m_b_hs;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    clear_agents();
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  // Load a burst into the master agent without running it.
  task automatic load_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [2:0] prot,
                            input int bad_last);
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; viol = 0;
    seen_bv = 0; b_done = 0;
    exp_r.delete(); sent_data.delete(); sent_strb.delete();
    cap_addr.delete(); cap_prot.delete(); cap_data.delete(); cap_strb.delete();
    master_aw_id = id; master_aw_addr = addr; master_aw_len = len;
    master_aw_size = size; master_aw_burst = burst; master_aw_prot = prot;
    exp_beats = int'(len) + 1;
    for (int i = 0; i <= int'(len); i++) begin
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      d = DW'($urandom);
      s = SW'($urandom);
      wq_data.push_back(d);
      wq_strb.push_back(s);
      wq_last.push_back((i == int'(len)) || (i == bad_last));
      sent_data.push_back(d);
      sent_strb.push_back(s);
    end
    aw_pend = 1;
  endtask

  task automatic run_burst(input string tag, input logic [IW-1:0] id,
                           input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [2:0] prot, input int bad_last,
                           input bit timed);
    int n;
    longint unsigned a, st, win, base;
    logic [AW-1:0] ea[$];
    logic [1:0] r;
    load_burst(id, addr, len, size, burst, prot, bad_last);
    n = 0;
    while (!b_done && n < 4000) begin
      step();
      n++;
    end
    if (!b_done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      do_reset();
      return;
    end

    // Expected Lite addresses from the burst rules
    st = 64'd1 << ((size > 3'd2) ? 2 : int'(size));
    a  = longint'(addr);
    for (int i = 0; i <= int'(len); i++) begin
      ea.push_back(AW'(a));
      if (burst == 2'd0) begin
        a = a;
      end else if (burst == 2'd2) begin
        win  = (longint'(len) + 1) * st;
        base = (a / win) * win;
        a    = base + ((a - base + st) % win);
      end else begin
        a = (a + st) % (64'd1 << AW);
      end
    end

    // Expected merged response
    r = 2'd0;
    foreach (exp_r[i]) begin
      logic [1:0] v;
      v = (exp_r[i] == 2'd1) ? 2'd0 : exp_r[i];
      if (v > r) r = v;
    end
`ifdef NASTI_LITE_WLAST_CHECK_EN
    if (bad_last >= 0 && bad_last != int'(len) && r < 2'd2) r = 2'd2;
`endif

    check({tag, "_naw"}, 64'(cap_addr.size()), 64'(exp_beats));
    check({tag, "_nw"},  64'(cap_data.size()), 64'(exp_beats));
    for (int i = 0; i < exp_beats; i++) begin
      if (i < cap_addr.size()) begin
        check({tag, "_addr"}, 64'(cap_addr[i]), 64'(ea[i]));
        check({tag, "_prot"}, 64'(cap_prot[i]), 64'(prot));
      end
      if (i < cap_data.size()) begin
        check({tag, "_data"}, 64'(cap_data[i]), 64'(sent_data[i]));
        check({tag, "_strb"}, 64'(cap_strb[i]), 64'(sent_strb[i]));
      end
    end
    check({tag, "_bid"},   64'(got_bid),   64'(id));
    check({tag, "_bresp"}, 64'(got_bresp), 64'(r));
    check({tag, "_proto"}, 64'(viol),      64'd0);
    if (timed)
      check({tag, "_lat"}, 64'(bv_cyc - aw_cyc), 64'(2 * (int'(len) + 1) + 1));
  endtask

  task automatic rand_bursts(input int count);
    logic [1:0]    bt;
    logic [2:0]    sz;
    logic [7:0]    ln;
    logic [AW-1:0] ad;
    int            es, bad;
    for (int k = 0; k < count; k++) begin
      bt = 2'($urandom_range(3));
      sz = 3'($urandom_range(3));
      es = (sz > 3'd2) ? 2 : int'(sz);
      if (bt == 2'd2) ln = 8'((2 << $urandom_range(3)) - 1);
      else            ln = 8'($urandom_range(15));
      ad = AW'(($urandom_range(16'hffff) >> es) << es);
      bad = -1;
      if (ln > 0 && $urandom_range(4) == 0) bad = $urandom_range(int'(ln) - 1);
      rdy_rand = 1;
      run_burst("rand", IW'($urandom), ad, ln, sz, bt, 3'($urandom), bad, 1'b0);
    end
  endtask

  task automatic reset_mid_burst();
    int n;
    rdy_rand = 0;
    load_burst(2'd2, 32'h4000, 8'd7, 3'd2, 2'd1, 3'd5, -1);
    n = 0;
    while (aw_cnt < 3 && n < 200) begin
      step();
      n++;
    end
    check("rst_reach_beat2", 64'(aw_cnt), 64'd3);
    #2;
    rstn = 0;
    #1;
    check("rst_lite_aw_valid",  64'(lite_aw_valid),   64'd0);
    check("rst_lite_w_valid",   64'(lite_w_valid),    64'd0);
    check("rst_master_w_ready", 64'(master_w_ready),  64'd0);
    check("rst_lite_b_ready",   64'(lite_b_ready),    64'd0);
    check("rst_master_b_valid", 64'(master_b_valid),  64'd0);
    check("rst_master_aw_ready",64'(master_aw_ready), 64'd1);
    check("rst_lite_aw_addr",   64'(lite_aw_addr),    64'd0);
    clear_agents();
    repeat (2) @(negedge clk);
    rstn = 1;
    #4;
    check("rst_no_stale_b", 64'(master_b_valid), 64'd0);
    run_burst("post_rst", 2'd1, 32'h0000_0500, 8'd0, 3'd2, 2'd1, 3'd0, -1, 1'b1);
  endtask

  initial begin
    cyc = 0; aw_cyc = 0; bv_cyc = 0; rdy_rand = 0;
    master_aw_id = '0; master_aw_addr = '0; master_aw_len = '0;
    master_aw_size = '0; master_aw_burst = '0; master_aw_prot = '0;
    rstn = 0;
    clear_agents();
    repeat (2) @(negedge clk);
    // Reset values
    check("reset_master_aw_ready", 64'(master_aw_ready), 64'd1);
    check("reset_lite_aw_valid",   64'(lite_aw_valid),   64'd0);
    check("reset_lite_w_valid",    64'(lite_w_valid),    64'd0);
    check("reset_master_w_ready",  64'(master_w_ready),  64'd0);
    check("reset_lite_b_ready",    64'(lite_b_ready),    64'd0);
    check("reset_master_b_valid",  64'(master_b_valid),  64'd0);
    check("reset_lite_aw_addr",    64'(lite_aw_addr),    64'd0);
    check("reset_lite_aw_prot",    64'(lite_aw_prot),    64'd0);
    check("reset_master_b_id",     64'(master_b_id),     64'd0);
    check("reset_master_b_resp",   64'(master_b_resp),   64'd0);
    rstn = 1;

    // Directed bursts with an always-ready slave
    rdy_rand = 0;
    rq = '{2'd0, 2'd0, 2'd0, 2'd0};
    run_burst("incr4", 2'd3, 32'h0000_1000, 8'd3, 3'd2, 2'd1, 3'd2, -1, 1'b1);
    rq = '{2'd0, 2'd0, 2'd0, 2'd0};
    run_burst("wrap4", 2'd1, 32'h0000_1008, 8'd3, 3'd2, 2'd2, 3'd1, -1, 1'b1);
    rq = '{2'd0, 2'd0};
    run_burst("fixed2", 2'd2, 32'h0000_0020, 8'd1, 3'd2, 2'd0, 3'd0, -1, 1'b1);
    rq = '{2'd0};
    run_burst("len0", 2'd0, 32'h0000_0040, 8'd0, 3'd2, 2'd1, 3'd7, -1, 1'b1);
    rq = '{2'd0, 2'd0, 2'd0};
    run_burst("rsvd_burst", 2'd1, 32'h0000_0080, 8'd2, 3'd1, 2'd3, 3'd0, -1, 1'b1);
    rq = '{2'd0, 2'd0};
    run_burst("size_cap", 2'd2, 32'h0000_00c0, 8'd1, 3'd3, 2'd1, 3'd0, -1, 1'b1);

    // Response merging
    rq = '{2'd0, 2'd2, 2'd0, 2'd0};
    run_burst("resp_slverr", 2'd1, 32'h0000_2000, 8'd3, 3'd2, 2'd1, 3'd0, -1, 1'b1);
    rq = '{2'd0, 2'd3, 2'd2, 2'd0};
    run_burst("resp_decerr", 2'd2, 32'h0000_2000, 8'd3, 3'd2, 2'd1, 3'd0, -1, 1'b1);
    rq = '{2'd1, 2'd1, 2'd1, 2'd1};
    run_burst("resp_exokay", 2'd3, 32'h0000_2000, 8'd3, 3'd2, 2'd1, 3'd0, -1, 1'b1);

    // Lite AW held off while W is ready: one W per beat, address stable
    rq = '{2'd0, 2'd0};
    aw_stall = 6;
    run_burst("aw_stall", 2'd0, 32'h0000_0300, 8'd1, 3'd2, 2'd1, 3'd3, -1, 1'b0);

    // master_w_last asserted early on beat 1
    rq = '{2'd0, 2'd0, 2'd0, 2'd0};
    run_burst("wlast_early", 2'd1, 32'h0000_3000, 8'd3, 3'd2, 2'd1, 3'd0, 1, 1'b1);

    reset_mid_burst();

    rand_bursts(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nasti_lite_writer.md
# nasti_lite_writer

Write-path adapter that turns one NASTI (AXI4) write burst into a sequence of single-beat NASTI-Lite writes, one per data beat, and returns one merged B response per burst. It sits directly downstream of the data-width narrower on the write path: it consumes the narrowed slave-side AW/W/B channels and drives Lite-only peripherals. It never handles more than one burst at a time.

## Interface
- ID_WIDTH, 2, NASTI ID width
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width on both sides (32 or 64)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- master_aw_id / _addr / _len / _size / _burst / _prot  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2 / 3  burst request fields
- master_aw_valid  in  1 ; master_aw_ready  out  1  AW handshake
- master_w_data / _strb / _last  in  DATA_WIDTH / DATA_WIDTH/8 / 1  write beat
- master_w_valid  in  1 ; master_w_ready  out  1  W handshake
- master_b_id / _resp  out  ID_WIDTH / 2  burst response
- master_b_valid  out  1 ; master_b_ready  in  1  B handshake
- lite_aw_addr / _prot  out  ADDR_WIDTH / 3  single-beat address
- lite_aw_valid  out  1 ; lite_aw_ready  in  1
- lite_w_data / _strb  out  DATA_WIDTH / DATA_WIDTH/8  single-beat data
- lite_w_valid  out  1 ; lite_w_ready  in  1
- lite_b_resp  in  2 ; lite_b_valid  in  1 ; lite_b_ready  out  1

## Operation
- States: S_IDLE, S_ADDR, S_RESP, S_BRESP.
- S_IDLE: master_aw_ready=1. On AW handshake, register id, addr, len, size, burst and prot. Clear beat counter cnt (8 bit), aw_done, w_done, and merged resp. Go to S_ADDR.
- S_ADDR:
  - lite_aw_valid = !aw_done.
  - lite_w_valid = !w_done & master_w_valid.
  - master_w_ready = !w_done & lite_w_ready.
  - W is a combinational pass-through of data and strb.
  - Set aw_done and w_done on their handshakes. When both are done (possibly in the same cycle), go to S_RESP.
- S_RESP: lite_b_ready=1. On lite B:
  - Merge resp as the maximum of OKAY(0)/SLVERR(2)/DECERR(3). EXOKAY(1) from Lite counts as OKAY.
  - If cnt==len, go to S_BRESP.
  - Otherwise increment cnt, advance the address, clear the done flags and go to S_ADDR.
- Address advance, with step = 1<<min(size, log2(DATA_WIDTH/8)):
  - FIXED: address unchanged.
  - INCR: addr + step.
  - WRAP: addr + step, wrapped inside the aligned window of (len+1)*step bytes.
  - Reserved burst type (3): treated as INCR.
- S_BRESP: master_b_valid=1 with the registered id and merged resp, held until master_b_ready; then go to S_IDLE.
- master_w_ready is 0 outside S_ADDR. W beats arriving early stall upstream and are never dropped.

## Timing
- Reset values:
  - state=S_IDLE.
  - master_aw_ready=1 (combinational from state).
  - All other valid/ready outputs 0.
  - lite_aw_addr, lite_aw_prot, master_b_id and master_b_resp are 0.
- lite_aw_addr and lite_aw_prot are registered and stable while lite_aw_valid=1.
- Per-beat minimum is 2 cycles (S_ADDR + S_RESP), with zero extra latency on W data.
- With an always-ready Lite slave, master_b_valid rises 2*(len+1)+1 cycles after the AW handshake.
- The next AW is accepted, at the earliest, the cycle after the B handshake.
- len=0 gives exactly one Lite transaction.
- Back-to-back rules:
  - lite_aw_valid and lite_w_valid never reassert for a beat already accepted.
  - A valid, once asserted, is not withdrawn until its handshake.
- Reset mid-burst: all outputs return to reset values immediately; the burst is abandoned and no B is issued.

## Configuration
- NASTI_LITE_WLAST_CHECK_EN defined:
  - master_w_last must be 1 exactly on beat cnt==len.
  - Any mismatch sets a sticky error that forces the burst's master_b_resp to at least SLVERR(2).
  - All len+1 Lite beats are still issued.
- Undefined: master_w_last is ignored, and the beat count comes solely from aw_len.

## Test plan
- INCR, len=3, size=2, addr 0x1000, Lite always ready and OKAY -> Lite AW 0x1000, 0x1004, 0x1008, 0x100C with matching data order; one B with id preserved and resp=0, b_valid 9 cycles after AW.
- WRAP, len=3, size=2, addr 0x1008 -> Lite AW 0x1008, 0x100C, 0x1000, 0x1004; FIXED, len=1, addr 0x20 -> both beats to 0x20.
- Lite B sequence OKAY, SLVERR, OKAY, OKAY -> master resp=2; sequence with one DECERR and one SLVERR -> resp=3; EXOKAY only -> resp=0.
- lite_aw_ready held low 5 cycles while lite_w_ready=1 -> W accepted once, master_w_ready low until the next beat, lite_aw_addr stable, no duplicate W.
- len=3 with master_w_last on beat 1: macro defined -> 4 Lite beats, resp=2; undefined -> 4 Lite beats, resp=0.
- rstn pulled low during beat 2 of len=7 -> all valids 0 asynchronously; after release, a new len=0 burst completes normally with no stale B.
